alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the 8-bit ALU interface (op/in0/in1 -> out).
- Accepts ALU commands over a valid/ready stream and drives operands and opcode into the combinational ALU.
- Captures and flags each result and returns it over a buffered valid/ready response stream.
- Holds an accumulator so chained operations can use the previous result as operand 0.

Parameters:
- WIDTH, 8, operand/result width; matches the ALU data width.
- RSP_DEPTH, 4, response FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  issuer accepts the command this cycle.
- cmd_op  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor; 101-111 illegal.
- cmd_a  input  WIDTH  operand 0, signed.
- cmd_b  input  WIDTH  operand 1, signed.
- cmd_use_acc  input  1  when 1, operand 0 is the accumulator and cmd_a is ignored.
- alu_in0  output  WIDTH  to ALU in0.
- alu_in1  output  WIDTH  to ALU in1.
- alu_op  output  3  to ALU op.
- alu_out  input  WIDTH  from ALU out; combinational function of alu_in0/alu_in1/alu_op.
- rsp_valid  output  1  response at FIFO head.
- rsp_ready  input  1  consumer takes the response.
- rsp_data  output  WIDTH  result.
- rsp_zero  output  1  result == 0.
- rsp_neg  output  1  result MSB.
- rsp_illegal  output  1  opcode was 101-111.
- busy  output  1  state != IDLE or FIFO not empty.

Behaviour:
- Reset (async assert, sync deassert is upstream):
  - state=IDLE.
  - alu_in0, alu_in1, alu_op = 0.
  - accumulator = 0.
  - FIFO emptied; rsp_valid=0, rsp_data/flags=0.
  - cmd_ready=0 while rst_n low.
  - Reset mid-operation discards the in-flight command and all buffered responses.
- FSM states:
  - IDLE -> ISSUE on accept (cmd_valid && cmd_ready).
  - ISSUE -> CAPTURE unconditionally.
  - CAPTURE -> IDLE unconditionally.
  - At most one command in flight.
- cmd_ready = (state==IDLE) && (fifo_count < RSP_DEPTH). Combinational, does not depend on cmd_valid.
- On accept (edge ending cycle N):
  - alu_in0 <= cmd_use_acc ? acc : cmd_a.
  - alu_in1 <= cmd_b.
  - alu_op <= cmd_op.
  - The illegal flag is latched.
- ISSUE (cycle N+1): ALU settle cycle; nothing sampled.
- CAPTURE (cycle N+2): alu_out is sampled at the end-of-cycle edge and pushed to the FIFO with its flags.
  - The accumulator is updated to alu_out only if the opcode is legal.
  - For illegal opcodes, the ALU's 0 output is passed through and flagged; the accumulator is unchanged.
- Latency:
  - rsp_valid rises in cycle N+3 when the FIFO was empty and not popped.
  - Next accept is possible in cycle N+3; throughput is 1 command per 3 cycles.
- alu_in0/alu_in1/alu_op hold their last issued values while IDLE and do not return to 0.
- Arithmetic: two's-complement modulo 2^WIDTH, no saturation, no overflow flag.
  - 127+1 -> -128.
  - -128-1 -> 127.
- FIFO:
  - First-word-fall-through: rsp_* show the head entry whenever rsp_valid=1.
  - Pop on rsp_valid && rsp_ready.
  - rsp_valid/rsp_* must stay stable while rsp_valid && !rsp_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo RSP_DEPTH.
  - Push never occurs when full, because cmd_ready already gated the accept.
- rsp_data/flags are 0 when the FIFO is empty.

Test Plan:
- Reset, then cmd add a=12 b=-4 -> alu_in0=12, alu_in1=-4 (0xfc), alu_op=000 one cycle after accept; response 8 (0x08), zero=0, neg=0, illegal=0, rsp_valid 3 cycles after accept.
- Chain: add 12,4 -> 16; then use_acc=1, sub b=16, cmd_a=99 -> alu_in0=16; result 0, zero=1; acc=0.
- Ops on a=0x55, b=0xf0:
  - and -> 0x50.
  - or -> 0xf5, neg=1.
  - xor -> 0xa5, neg=1.
  - op=101 -> 0x00, illegal=1, zero=1, acc unchanged at 0xa5.
  - Next use_acc add b=1 -> 0xa6.
- Wrap: add 127,1 -> -128 (0x80), neg=1; sub -128,1 -> 127 (0x7f), neg=0.
- Backpressure: rsp_ready=0, cmd_valid held with 5 commands (add i,0 for i=1..5).
  - Exactly 4 accepted; cmd_ready stays 0; head stays 1.
  - Then rsp_ready=1 -> drains 1,2,3,4.
  - The 5th is accepted once room exists and returns 5.
  - busy falls after the last pop.
- Reset mid-operation: assert rst_n=0 in the ISSUE cycle with 2 responses buffered.
  - Immediately rsp_valid=0, alu_* = 0, cmd_ready=0.
  - After release, no stale response appears and acc=0.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Initiator for an 8-bit combinational ALU.
// Takes commands over a valid/ready stream and drives operands and opcode into the ALU.
// Captures each result together with its flags into a first-word-fall-through response FIFO.
// Keeps an accumulator so that a command can use the previous legal result as operand 0.
module alu_cmd_issuer #(
    parameter int WIDTH     = 8,
    parameter int RSP_DEPTH = 4   // power of two, >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_illegal,
    output logic             busy
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             neg;
        logic             illegal;
    } rsp_t;

    state_t           state_q;
    logic [WIDTH-1:0] alu_in0_q, alu_in1_q, acc_q;
    logic [2:0]       alu_op_q;
    logic             illegal_q;

    rsp_t             mem_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic  accept, push, pop;
    rsp_t  push_entry, head;

    // Ready is held low during reset even though the state already reads IDLE.
    assign cmd_ready = rst_n && (state_q == IDLE) && (count_q < DEPTH_C);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state_q == CAPTURE);
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (state_q != IDLE) || rsp_valid;

    assign push_entry = '{data:    alu_out,
                          zero:    (alu_out == '0),
                          neg:     alu_out[WIDTH-1],
                          illegal: illegal_q};

    // Head entry is shown only while valid; an empty FIFO reads as all zeros.
    assign head        = rsp_valid ? mem_q[rd_ptr_q] : '0;
    assign rsp_data    = head.data;
    assign rsp_zero    = head.zero;
    assign rsp_neg     = head.neg;
    assign rsp_illegal = head.illegal;

    assign alu_in0 = alu_in0_q;
    assign alu_in1 = alu_in1_q;
    assign alu_op  = alu_op_q;

    // Issue FSM: latch operands on accept, wait one settle cycle, then capture the result.
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            alu_in0_q <= '0;
            alu_in1_q <= '0;
            alu_op_q  <= '0;
            illegal_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_in0_q <= cmd_use_acc ? acc_q : cmd_a;
                        alu_in1_q <= cmd_b;
                        alu_op_q  <= cmd_op;
                        illegal_q <= (cmd_op > 3'd4);
                        state_q   <= ISSUE;
                    end
                end
                ISSUE:   state_q <= CAPTURE;
                CAPTURE: begin
                    if (!illegal_q) acc_q <= alu_out;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next-state pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    // NOTE: every output is given a default first so that no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers; reset discards every buffered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage write on capture.
    // NOTE: storage is not reset; stale entries are unreachable because the count is reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed testbench for alu_cmd_issuer with a behavioural model of the combinational ALU.
// Inputs are driven on falling edges and outputs are sampled there.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_use_acc;
    logic [2:0] cmd_op, alu_op;
    logic [7:0] cmd_a, cmd_b, alu_in0, alu_in1, alu_out;
    logic       rsp_valid, rsp_ready, rsp_zero, rsp_neg, rsp_illegal, busy;
    logic [7:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Reference ALU: the result is the wrapped 8-bit value; illegal opcodes give 0.
    always_comb begin
        case (alu_op)
            3'b000:  alu_out = alu_in0 + alu_in1;
            3'b001:  alu_out = alu_in0 - alu_in1;
            3'b010:  alu_out = alu_in0 & alu_in1;
            3'b011:  alu_out = alu_in0 | alu_in1;
            3'b100:  alu_out = alu_in0 ^ alu_in1;
            default: alu_out = 8'h00;
        endcase
    end

    alu_cmd_issuer #(.WIDTH(8), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_illegal(rsp_illegal),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a command, waits (bounded) for it to be accepted and returns in cycle N+1.
    task automatic send(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ua);
        int waited = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a response, checks it and pops it with a one-cycle ready pulse.
    task automatic get_rsp(input string tag, input logic [7:0] d, input logic z,
                           input logic n, input logic il);
        int waited = 0;
        while (!rsp_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_data"}, rsp_data, d);
        check({tag, "_zero"}, rsp_zero, z);
        check({tag, "_neg"}, rsp_neg, n);
        check({tag, "_illegal"}, rsp_illegal, il);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_use_acc = 1'b0; rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_alu_in0", alu_in0, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        // add 12 + (-4) with exact latency
        send("add1", 3'b000, 8'd12, 8'hfc, 1'b0);
        check("add1_in0", alu_in0, 8'h0c);
        check("add1_in1", alu_in1, 8'hfc);
        check("add1_op", alu_op, 3'b000);
        check("add1_busy", busy, 1);
        check("add1_ready_n1", cmd_ready, 0);
        check("add1_valid_n1", rsp_valid, 0);
        @(negedge clk);
        check("add1_valid_n2", rsp_valid, 0);
        @(negedge clk);
        check("add1_valid_n3", rsp_valid, 1);
        check("add1_ready_n3", cmd_ready, 1);
        get_rsp("add1", 8'h08, 1'b0, 1'b0, 1'b0);
        check("add1_empty_valid", rsp_valid, 0);
        check("add1_empty_data", rsp_data, 0);

        // Accumulator chain: 12+4=16, then acc-16 = 0 with cmd_a ignored
        send("chain_add", 3'b000, 8'd12, 8'd4, 1'b0);
        get_rsp("chain_add", 8'h10, 1'b0, 1'b0, 1'b0);
        send("chain_sub", 3'b001, 8'd99, 8'd16, 1'b1);
        check("chain_sub_in0", alu_in0, 8'h10);
        get_rsp("chain_sub", 8'h00, 1'b1, 1'b0, 1'b0);

        // Logic ops, illegal opcode, accumulator preserved across illegal
        send("and", 3'b010, 8'h55, 8'hf0, 1'b0);
        get_rsp("and", 8'h50, 1'b0, 1'b0, 1'b0);
        send("or", 3'b011, 8'h55, 8'hf0, 1'b0);
        get_rsp("or", 8'hf5, 1'b0, 1'b1, 1'b0);
        send("xor", 3'b100, 8'h55, 8'hf0, 1'b0);
        get_rsp("xor", 8'ha5, 1'b0, 1'b1, 1'b0);
        send("ill", 3'b101, 8'h55, 8'hf0, 1'b0);
        check("ill_op", alu_op, 3'b101);
        get_rsp("ill", 8'h00, 1'b1, 1'b0, 1'b1);
        send("acc_add", 3'b000, 8'h00, 8'h01, 1'b1);
        check("acc_add_in0", alu_in0, 8'ha5);
        get_rsp("acc_add", 8'ha6, 1'b0, 1'b1, 1'b0);

        // Two's-complement wrap
        send("wrap_add", 3'b000, 8'h7f, 8'h01, 1'b0);
        get_rsp("wrap_add", 8'h80, 1'b0, 1'b1, 1'b0);
        send("wrap_sub", 3'b001, 8'h80, 8'h01, 1'b0);
        get_rsp("wrap_sub", 8'h7f, 1'b0, 1'b0, 1'b0);
        check("wrap_idle_busy", busy, 0);

        // Backpressure: four fill the FIFO, the fifth waits for room
        for (int i = 1; i <= 4; i++) send("bp_fill", 3'b000, 8'(i), 8'h00, 1'b0);
        check("bp_head_early", rsp_data, 8'h01);
        cmd_op = 3'b000; cmd_a = 8'd5; cmd_b = 8'h00; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        repeat (6) @(negedge clk);
        check("bp_full_ready", cmd_ready, 0);
        check("bp_full_head", rsp_data, 8'h01);
        check("bp_full_busy", busy, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_drain2", rsp_data, 8'h02);
        check("bp_room_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_drain3", rsp_data, 8'h03);
        check("bp_5th_in0", alu_in0, 8'h05);
        @(negedge clk);
        check("bp_drain4", rsp_data, 8'h04);
        @(negedge clk);
        check("bp_drain5_valid", rsp_valid, 1);
        check("bp_drain5", rsp_data, 8'h05);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_done_valid", rsp_valid, 0);
        check("bp_done_busy", busy, 0);

        // Reset in the ISSUE cycle with two responses buffered
        send("mr1", 3'b000, 8'd1, 8'd1, 1'b0);
        send("mr2", 3'b000, 8'd2, 8'd2, 1'b0);
        send("mr3", 3'b000, 8'd3, 8'd3, 1'b0);
        check("mr_pre_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_alu_in0", alu_in0, 0);
        check("mr_alu_in1", alu_in1, 0);
        check("mr_alu_op", alu_op, 0);
        check("mr_cmd_ready", cmd_ready, 0);
        check("mr_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mr_no_stale", rsp_valid, 0);
        send("mr_acc", 3'b000, 8'h77, 8'd3, 1'b1);
        check("mr_acc_in0", alu_in0, 8'h00);
        get_rsp("mr_acc", 8'h03, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
